reg_bank_reader: RTL and testbench

- Read-side counterpart to the write-enabled register bank built from FF instances.
- On a start request it snapshots a flattened bank of NUM_REGS words. It then streams them out one word per transfer over a valid/ready interface, index 0 first.
- Sits between the datapath register bank and any downstream consumer (serializer, output port, checker).
- Snapshotting isolates the readout from writes that land during streaming.

---
 rtl/reg_bank_reader_pkg.sv | 10 +
 rtl/reg_bank_reader_ff.sv | 17 +
 rtl/reg_bank_reader.sv | 98 +++++++++
 tb/tb_reg_bank_reader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_reader_pkg.sv
// Shared state encoding for the register-bank readout engine.
package reg_bank_reader_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE   = 2'd0,
    STATE_STREAM = 2'd1,
    STATE_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/reg_bank_reader_ff.sv
// Write-enabled register with asynchronous active-low clear.
module reg_bank_reader_ff #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  WrEn_SI,
  input  logic [DATA_WIDTH-1:0] D_DI,
  output logic [DATA_WIDTH-1:0] Q_DO
);

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI)     Q_DO <= '0;
    else if (WrEn_SI) Q_DO <= D_DI;
  end

endmodule

// File: rtl/reg_bank_reader.sv
// Snapshots a flattened register bank on request and streams it out word by
// word over valid/ready, index 0 first, then pulses Done_SO for one cycle.
module reg_bank_reader
  import reg_bank_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int NUM_REGS   = 8,
  parameter int IDX_WIDTH  = 3
) (
  input  logic                           Clk_CI,
  input  logic                           Rst_RBI,
  input  logic                           Start_SI,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] Bank_DI,
  input  logic                           Ready_SI,
  output logic                           Valid_SO,
  output logic [DATA_WIDTH-1:0]          Data_DO,
  output logic [IDX_WIDTH-1:0]           Idx_DO,
  output logic                           Last_SO,
  output logic                           Busy_SO,
  output logic                           Done_SO
);

  localparam int                   BANK_W   = NUM_REGS * DATA_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REGS - 1);

  if (NUM_REGS < 2 || IDX_WIDTH != $clog2(NUM_REGS)) begin : g_param_chk
    $error("reg_bank_reader: NUM_REGS must be >= 2 and IDX_WIDTH = clog2(NUM_REGS)");
  end

  state_e                              r_state;
  logic [IDX_WIDTH-1:0]                r_idx;
  logic [BANK_W-1:0]                   w_snap;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] w_words;
  logic                                w_capture;
  logic                                w_stream;
  logic                                w_xfer;

  assign w_capture = (r_state == STATE_IDLE) && Start_SI;
  assign w_stream  = (r_state == STATE_STREAM);
  assign w_xfer    = w_stream && Ready_SI;

  // Snapshot decouples the readout from bank writes landing mid-stream.
  reg_bank_reader_ff #(
    .DATA_WIDTH (BANK_W)
  ) u_snap (
    .Clk_CI  (Clk_CI),
    .Rst_RBI (Rst_RBI),
    .WrEn_SI (w_capture),
    .D_DI    (Bank_DI),
    .Q_DO    (w_snap)
  );

  assign w_words = w_snap;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_state <= STATE_IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        STATE_IDLE: begin
          if (Start_SI) begin
            r_state <= STATE_STREAM;
            r_idx   <= '0;
          end
        end
        STATE_STREAM: begin
          // Saturate at the last word so non-power-of-two banks never wrap
          // through unused index codes.
          if (w_xfer) begin
            if (r_idx == LAST_IDX) begin
              r_state <= STATE_DONE;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + IDX_WIDTH'(1);
            end
          end
        end
        STATE_DONE: begin
          r_state <= STATE_IDLE;
          r_idx   <= '0;
        end
        default: begin
          r_state <= STATE_IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign Valid_SO = w_stream;
  assign Busy_SO  = w_stream;
  assign Done_SO  = (r_state == STATE_DONE);
  assign Idx_DO   = w_stream ? r_idx : '0;
  assign Last_SO  = w_stream && (r_idx == LAST_IDX);
  assign Data_DO  = w_stream ? w_words[r_idx] : '0;

endmodule

// File: tb/tb_reg_bank_reader.sv
// Bench for reg_bank_reader: table-driven full-rate stream, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_reg_bank_reader;

  localparam int DW = 10;
  localparam int NR = 4;
  localparam int IW = 2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [NR*DW-1:0] bank;
  logic             ready;
  logic             valid;
  logic [DW-1:0]    data;
  logic [IW-1:0]    idx;
  logic             last;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  reg_bank_reader #(
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .IDX_WIDTH  (IW)
  ) dut (
    .Clk_CI   (clk),
    .Rst_RBI  (rst_n),
    .Start_SI (start),
    .Bank_DI  (bank),
    .Ready_SI (ready),
    .Valid_SO (valid),
    .Data_DO  (data),
    .Idx_DO   (idx),
    .Last_SO  (last),
    .Busy_SO  (busy),
    .Done_SO  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a readout is simply the queue of words still owed.
  logic [DW-1:0] m_q[$];
  bit            m_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_done = 1'b0;
  endtask

  task automatic model_tick();
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_q.size() == 0) begin
      if (start) for (int i = 0; i < NR; i++) m_q.push_back(bank[i*DW +: DW]);
    end else if (ready) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) m_done = 1'b1;
    end
  endtask

  task automatic check_model();
    logic ev;
    ev = (m_q.size() > 0);
    chk("valid", 32'(valid), 32'(ev));
    chk("busy",  32'(busy),  32'(ev));
    chk("data",  32'(data),  ev ? 32'(m_q[0]) : 32'd0);
    chk("idx",   32'(idx),   ev ? 32'(NR - m_q.size()) : 32'd0);
    chk("last",  32'(last),  32'(m_q.size() == 1));
    chk("done",  32'(done),  32'(m_done));
  endtask

  task automatic cyc();
    model_tick();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic rst_cycle();
    @(posedge clk);
    #1;
    model_reset();
    check_model();
  endtask

  typedef struct {
    logic          start;
    logic          ready;
    logic          v;
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
    logic          done;
  } vec_t;

  vec_t          tbl[6];
  logic [NR*DW-1:0] std_bank;
  int            ndone;

  initial begin
    std_bank = {10'h001, 10'h2AA, 10'h155, 10'h3FF};
    tbl[0] = '{1'b1, 1'b1, 1'b1, 10'h3FF, 2'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 10'h155, 2'd1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 10'h2AA, 2'd2, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 10'h001, 2'd3, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 10'h000, 2'd0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 10'h000, 2'd0, 1'b0, 1'b0};

    // Reset with random inputs toggling
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    bank  = '0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom);
      ready = 1'($urandom);
      bank  = {$urandom, $urandom};
      rst_cycle();
    end
    start = 1'b0;
    ready = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc();

    // Full-rate stream from the vector table
    bank = std_bank;
    for (int i = 0; i < 6; i++) begin
      start = tbl[i].start;
      ready = tbl[i].ready;
      cyc();
      chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_data", i),  32'(data),  32'(tbl[i].data));
      chk($sformatf("tbl%0d_idx", i),   32'(idx),   32'(tbl[i].idx));
      chk($sformatf("tbl%0d_last", i),  32'(last),  32'(tbl[i].last));
      chk($sformatf("tbl%0d_done", i),  32'(done),  32'(tbl[i].done));
    end

    // Backpressure at index 2
    start = 1'b1; ready = 1'b1; cyc();
    start = 1'b0; cyc(); cyc();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_data", 32'(data), 32'h2AA);
      chk("bp_idx",  32'(idx),  32'd2);
    end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc();

    // Snapshot isolation: bank word 1 rewritten after capture
    start = 1'b1; cyc();
    start = 1'b0;
    bank[1*DW +: DW] = 10'h0F0;
    cyc();
    chk("iso_idx",  32'(idx),  32'd1);
    chk("iso_word", 32'(data), 32'h155);
    for (int i = 0; i < 4; i++) cyc();
    bank = std_bank;

    // Start held high through STREAM and DONE
    start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (done) ndone++;
    end
    chk("held_start_done_count", 32'(ndone), 32'd1);
    cyc();
    chk("restart_idx0_valid", 32'(valid), 32'd1);
    chk("restart_idx0", 32'(idx), 32'd0);
    start = 1'b0;
    for (int i = 0; i < 5; i++) cyc();

    // Reset mid-stream at index 2
    start = 1'b1; cyc();
    start = 1'b0; cyc(); cyc();
    chk("pre_rst_idx", 32'(idx), 32'd2);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    rst_cycle();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (done) ndone++;
    end
    chk("rst_no_done", 32'(ndone), 32'd0);
    start = 1'b1; cyc();
    start = 1'b0;
    chk("post_rst_idx", 32'(idx), 32'd0);
    chk("post_rst_data", 32'(data), 32'h3FF);
    for (int i = 0; i < 5; i++) cyc();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      start = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 0) bank = {$urandom, $urandom};
      cyc();
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model();
        rst_cycle();
        rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
